// File: rtl/mac_rx_pkg.sv
// Shared types for the MAC receive read controller: FSM states, EOP byte-enable
// encodings, descriptor layout and the byte-enable decode helper.
package mac_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_RECV = 3'd2,
    ST_DROP = 3'd3,
    ST_DESC = 3'd4
  } rx_state_t;

  // mac_ben_i encodings: number of valid bytes in the EOP word.
  localparam logic [1:0] BEN_4 = 2'b00;
  localparam logic [1:0] BEN_1 = 2'b01;
  localparam logic [1:0] BEN_2 = 2'b10;
  localparam logic [1:0] BEN_3 = 2'b11;

  localparam int DESC_ADDR_W = 12;
  localparam int DESC_LEN_W  = 16;

  typedef struct packed {
    logic [DESC_ADDR_W-1:0] addr;
    logic [DESC_LEN_W-1:0]  len;
    logic                   err;
  } rx_desc_t;

  function automatic logic [2:0] ben_to_bytes(input logic [1:0] ben);
    case (ben)
      BEN_1:   return 3'd1;
      BEN_2:   return 3'd2;
      BEN_3:   return 3'd3;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mac_rx_read_ctrl_if.sv
// MAC RX client, buffer write port and descriptor channel of mac_rx_read_ctrl.
// Descriptor handshake: desc_valid_o rises with stable fields and holds them
// until the cycle desc_ready_i is sampled high; the transfer happens on that edge.
interface mac_rx_read_ctrl_if
  import mac_rx_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int LEN_W  = 16
) ();
  logic [31:0]       mac_rxd_i;
  logic [1:0]        mac_ben_i;
  logic              mac_rxda_i;
  logic              mac_rxsop_i;
  logic              mac_rxeop_i;
  logic              mac_rxdv_i;
  logic              mac_rxrqrd_o;
  logic [ADDR_W:0]   buf_rd_ptr_i;
  logic              buf_wr_en_o;
  logic [ADDR_W-1:0] buf_wr_addr_o;
  logic [31:0]       buf_wr_data_o;
  logic              desc_valid_o;
  logic              desc_ready_i;
  logic [ADDR_W-1:0] desc_addr_o;
  logic [LEN_W-1:0]  desc_len_o;
  logic              desc_err_o;
  logic [ADDR_W:0]   wr_ptr_o;
  rx_state_t         state_o;

  modport master (
    input  mac_rxd_i, mac_ben_i, mac_rxda_i, mac_rxsop_i, mac_rxeop_i, mac_rxdv_i,
    input  buf_rd_ptr_i, desc_ready_i,
    output mac_rxrqrd_o, buf_wr_en_o, buf_wr_addr_o, buf_wr_data_o,
    output desc_valid_o, desc_addr_o, desc_len_o, desc_err_o, wr_ptr_o, state_o
  );

  modport slave (
    output mac_rxd_i, mac_ben_i, mac_rxda_i, mac_rxsop_i, mac_rxeop_i, mac_rxdv_i,
    output buf_rd_ptr_i, desc_ready_i,
    input  mac_rxrqrd_o, buf_wr_en_o, buf_wr_addr_o, buf_wr_data_o,
    input  desc_valid_o, desc_addr_o, desc_len_o, desc_err_o, wr_ptr_o, state_o
  );
endinterface

// File: rtl/mac_rx_ptr_ctrl.sv
// Working/committed write pointers for the circular RX buffer and the free-space
// figure used for frame admission. Free space is always based on the committed
// pointer so an uncommitted partial frame never hides space from the consumer.
module mac_rx_ptr_ctrl #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              adv,
  input  logic              rewind,
  input  logic              commit,
  input  logic [ADDR_W:0]   rd_ptr,
  output logic [ADDR_W-1:0] work_addr,
  output logic [ADDR_W:0]   commit_ptr,
  output logic [ADDR_W:0]   free_words
);
  logic [ADDR_W:0] work_ptr;
  logic [ADDR_W:0] used_words;

  // Working pointer follows written words; commit publishes it, rewind discards it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_ptr   <= '0;
      commit_ptr <= '0;
    end else begin
      if (rewind)   work_ptr <= commit_ptr;
      else if (adv) work_ptr <= work_ptr + 1'b1;
      if (commit)   commit_ptr <= work_ptr;
    end
  end

  assign used_words = commit_ptr - rd_ptr;
  assign free_words = {1'b1, {ADDR_W{1'b0}}} - used_words;
  assign work_addr  = work_ptr[ADDR_W-1:0];
endmodule

// File: rtl/mac_rx_read_ctrl.sv
// Requests frames from the tri-mode MAC, writes each received word into the
// circular buffer one cycle later, and emits one descriptor per frame. Frames
// are only admitted when a maximum-size frame fits, so no overflow mid-frame.
module mac_rx_read_ctrl
  import mac_rx_pkg::*;
#(
  parameter int ADDR_W          = 12,
  parameter int MAX_FRAME_WORDS = 380,
  parameter int LEN_W           = 16
) (
  input logic mac_clk_i,
  input logic mac_rst_n_i,
  mac_rx_read_ctrl_if.master bus
);
  localparam logic [ADDR_W:0]  ADMIT_MIN = (ADDR_W+1)'(MAX_FRAME_WORDS);
  localparam logic [LEN_W-1:0] LAST_CNT  = LEN_W'(MAX_FRAME_WORDS - 1);

  rx_state_t         state;
  logic [LEN_W-1:0]  word_cnt;
  logic              rqrd_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [31:0]       wr_data_q;
  logic              desc_valid_q;
  logic              desc_err_q;
  logic [ADDR_W-1:0] desc_addr_q;
  logic [LEN_W-1:0]  desc_len_q;
  logic [ADDR_W-1:0] work_addr;
  logic [ADDR_W:0]   wptr_commit;
  logic [ADDR_W:0]   free_words;
  logic              ptr_adv;
  logic              ptr_rewind;
  logic              ptr_commit;
  logic              admit;
  logic [LEN_W-1:0]  eop_len;

  mac_rx_ptr_ctrl #(.ADDR_W(ADDR_W)) u_ptr (
    .clk        (mac_clk_i),
    .rst_n      (mac_rst_n_i),
    .adv        (ptr_adv),
    .rewind     (ptr_rewind),
    .commit     (ptr_commit),
    .rd_ptr     (bus.buf_rd_ptr_i),
    .work_addr  (work_addr),
    .commit_ptr (wptr_commit),
    .free_words (free_words)
  );

  // Pointer strobes: a word advances the working pointer only when it is stored.
  always_comb begin
    ptr_adv    = 1'b0;
    ptr_rewind = (state == ST_IDLE) || (state == ST_DROP);
    ptr_commit = (state == ST_DESC) && bus.desc_ready_i && !desc_err_q;
    case (state)
      ST_REQ:  ptr_adv = bus.mac_rxdv_i && bus.mac_rxsop_i;
      ST_RECV: ptr_adv = bus.mac_rxdv_i && !bus.mac_rxsop_i;
      default: ptr_adv = 1'b0;
    endcase
  end

  assign admit   = bus.mac_rxda_i && (free_words >= ADMIT_MIN) && !desc_valid_q;
  // In REQ the EOP word is the only word; in RECV word_cnt already counts the earlier words.
  assign eop_len = (state == ST_REQ) ? LEN_W'(ben_to_bytes(bus.mac_ben_i))
                 : {word_cnt[LEN_W-3:0], 2'b00} + LEN_W'(ben_to_bytes(bus.mac_ben_i));

  // Frame sequencer: state, request, write pipeline and descriptor registers.
  always_ff @(posedge mac_clk_i or negedge mac_rst_n_i) begin
    if (!mac_rst_n_i) begin
      state        <= ST_IDLE;
      word_cnt     <= '0;
      rqrd_q       <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      desc_valid_q <= 1'b0;
      desc_err_q   <= 1'b0;
      desc_addr_q  <= '0;
      desc_len_q   <= '0;
    end else begin
      rqrd_q  <= (state == ST_REQ) || (state == ST_RECV) || (state == ST_DROP);
      wr_en_q <= ptr_adv;
      if (ptr_adv) begin
        wr_addr_q <= work_addr;
        wr_data_q <= bus.mac_rxd_i;
      end
      case (state)
        ST_IDLE: if (admit) state <= ST_REQ;
        ST_REQ: begin
          if (bus.mac_rxdv_i) begin
            if (bus.mac_rxsop_i) begin
              word_cnt    <= LEN_W'(1);
              desc_addr_q <= work_addr;
              if (bus.mac_rxeop_i) begin
                desc_valid_q <= 1'b1;
                desc_err_q   <= 1'b0;
                desc_len_q   <= eop_len;
                state        <= ST_DESC;
              end else begin
                state <= ST_RECV;
              end
            end else if (bus.mac_rxeop_i) begin
              desc_valid_q <= 1'b1;
              desc_err_q   <= 1'b1;
              desc_len_q   <= '0;
              desc_addr_q  <= wptr_commit[ADDR_W-1:0];
              state        <= ST_DESC;
            end else begin
              state <= ST_DROP;
            end
          end else if (!bus.mac_rxda_i) begin
            state <= ST_IDLE;
          end
        end
        ST_RECV: begin
          if (bus.mac_rxdv_i) begin
            if (bus.mac_rxsop_i) begin
              if (bus.mac_rxeop_i) begin
                desc_valid_q <= 1'b1;
                desc_err_q   <= 1'b1;
                desc_len_q   <= '0;
                desc_addr_q  <= wptr_commit[ADDR_W-1:0];
                state        <= ST_DESC;
              end else begin
                state <= ST_DROP;
              end
            end else begin
              word_cnt <= word_cnt + 1'b1;
              if (bus.mac_rxeop_i) begin
                desc_valid_q <= 1'b1;
                desc_err_q   <= 1'b0;
                desc_len_q   <= eop_len;
                state        <= ST_DESC;
              end else if (word_cnt == LAST_CNT) begin
                state <= ST_DROP;
              end
            end
          end
        end
        ST_DROP: begin
          // Error descriptors point at the committed pointer, where the next frame lands.
          if (bus.mac_rxdv_i && bus.mac_rxeop_i) begin
            desc_valid_q <= 1'b1;
            desc_err_q   <= 1'b1;
            desc_len_q   <= '0;
            desc_addr_q  <= wptr_commit[ADDR_W-1:0];
            state        <= ST_DESC;
          end
        end
        ST_DESC: begin
          if (bus.desc_ready_i) begin
            desc_valid_q <= 1'b0;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.mac_rxrqrd_o  = rqrd_q;
  assign bus.buf_wr_en_o   = wr_en_q;
  assign bus.buf_wr_addr_o = wr_addr_q;
  assign bus.buf_wr_data_o = wr_data_q;
  assign bus.desc_valid_o  = desc_valid_q;
  assign bus.desc_addr_o   = desc_addr_q;
  assign bus.desc_len_o    = desc_len_q;
  assign bus.desc_err_o    = desc_err_q;
  assign bus.wr_ptr_o      = wptr_commit;
  assign bus.state_o       = state;
endmodule

// File: tb/tb_mac_rx_read_ctrl.sv
// Directed bench for mac_rx_read_ctrl: a frame-level model predicts every buffer
// write, every descriptor and the committed pointer; literal checks pin the model.
module tb_mac_rx_read_ctrl;
  import mac_rx_pkg::*;

  localparam int AW   = 12;
  localparam int LW   = 16;
  localparam int MAXW = 380;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mac_rx_read_ctrl_if #(.ADDR_W(AW), .LEN_W(LW)) bus ();

  mac_rx_read_ctrl #(.ADDR_W(AW), .MAX_FRAME_WORDS(MAXW), .LEN_W(LW)) dut (
    .mac_clk_i   (clk),
    .mac_rst_n_i (rst_n),
    .bus         (bus)
  );

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;
  logic [AW+31:0] exp_q[$];        // {addr, data} of every expected buffer write
  rx_desc_t       exp_desc_q[$];
  int             exp_words_q[$];  // words a good frame adds to the committed pointer
  logic [AW:0]    model_wr_ptr = '0;
  rx_desc_t       last_desc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: event missing or unexpected at %0t", name, $time);
  endtask

  // Compare process: outputs are checked mid-cycle against the frame model.
  always @(negedge clk) begin : cmp
    logic [AW+31:0] e;
    rx_desc_t d;
    int w;
    if (!rst_n) begin
      exp_q.delete();
      exp_desc_q.delete();
      exp_words_q.delete();
      model_wr_ptr = '0;
    end else begin
      check("wr_ptr", 64'(bus.wr_ptr_o), 64'(model_wr_ptr));
      if (bus.buf_wr_en_o) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_write");
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 64'(bus.buf_wr_addr_o), 64'(e[AW+31:32]));
          check("wr_data", 64'(bus.buf_wr_data_o), 64'(e[31:0]));
        end
      end
      if (bus.desc_valid_o) begin
        if (exp_desc_q.size() == 0) begin
          fail_now("unexpected_desc");
        end else begin
          d = exp_desc_q[0];
          check("desc_addr", 64'(bus.desc_addr_o), 64'(d.addr));
          check("desc_len", 64'(bus.desc_len_o), 64'(d.len));
          check("desc_err", 64'(bus.desc_err_o), 64'(d.err));
          if (bus.desc_ready_i) begin
            d = exp_desc_q.pop_front();
            w = exp_words_q.pop_front();
            last_desc.addr = bus.desc_addr_o;
            last_desc.len  = bus.desc_len_o;
            last_desc.err  = bus.desc_err_o;
            if (!d.err) model_wr_ptr = model_wr_ptr + (AW+1)'(w);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_all_zero(input string tag);
    check({tag, "_rqrd"},  64'(bus.mac_rxrqrd_o), 64'd0);
    check({tag, "_wr_en"}, 64'(bus.buf_wr_en_o), 64'd0);
    check({tag, "_wr_ad"}, 64'(bus.buf_wr_addr_o), 64'd0);
    check({tag, "_wr_dt"}, 64'(bus.buf_wr_data_o), 64'd0);
    check({tag, "_dvld"},  64'(bus.desc_valid_o), 64'd0);
    check({tag, "_dadr"},  64'(bus.desc_addr_o), 64'd0);
    check({tag, "_dlen"},  64'(bus.desc_len_o), 64'd0);
    check({tag, "_derr"},  64'(bus.desc_err_o), 64'd0);
    check({tag, "_wptr"},  64'(bus.wr_ptr_o), 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Sends one frame. bad_sop >= 1 puts a stray SOP on that word; abort_at >= 0
  // stops after that many words with no descriptor expected.
  task automatic send_frame(input int nwords, input logic [1:0] ben, input bit first_sop,
                            input int bad_sop, input int abort_at, input int rdy_delay);
    logic [AW:0]   base;
    logic [AW-1:0] a;
    logic [31:0]   d;
    rx_desc_t      dsc;
    bit            err;
    bit            ok;
    int            nbytes;
    base   = model_wr_ptr;
    err    = !first_sop || (bad_sop > 0) || (nwords > MAXW);
    nbytes = (ben == 2'b00) ? 4 : int'(ben);
    if (abort_at < 0) begin
      dsc.addr = base[AW-1:0];
      dsc.len  = err ? 16'd0 : 16'((nwords - 1) * 4 + nbytes);
      dsc.err  = err;
      exp_desc_q.push_back(dsc);
      exp_words_q.push_back(nwords);
    end
    bus.buf_rd_ptr_i = model_wr_ptr;
    bus.mac_rxda_i   = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (bus.mac_rxrqrd_o) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      fail_now("rqrd_timeout");
      bus.mac_rxda_i = 1'b0;
      exp_desc_q.delete();
      exp_words_q.delete();
      return;
    end
    for (int i = 0; i < nwords; i++) begin
      if (abort_at >= 0 && i == abort_at) break;
      d = $urandom;
      bus.mac_rxd_i   = d;
      bus.mac_ben_i   = ben;
      bus.mac_rxdv_i  = 1'b1;
      bus.mac_rxsop_i = (i == 0 && first_sop) || (i == bad_sop);
      bus.mac_rxeop_i = (i == nwords - 1);
      if (first_sop && (bad_sop <= 0 || i < bad_sop) && i < MAXW) begin
        a = base[AW-1:0] + AW'(i);
        exp_q.push_back({a, d});
      end
      @(posedge clk);
      #1;
    end
    bus.mac_rxdv_i  = 1'b0;
    bus.mac_rxsop_i = 1'b0;
    bus.mac_rxeop_i = 1'b0;
    bus.mac_rxda_i  = 1'b0;
    if (abort_at >= 0) return;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (bus.desc_valid_o) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      fail_now("desc_timeout");
      exp_desc_q.delete();
      exp_words_q.delete();
    end else begin
      repeat (rdy_delay) begin
        @(posedge clk);
        #1;
      end
      bus.desc_ready_i = 1'b1;
      @(posedge clk);
      #1;
      bus.desc_ready_i = 1'b0;
    end
    check("writes_drained", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n            = 1'b0;
    bus.mac_rxd_i    = '0;
    bus.mac_ben_i    = '0;
    bus.mac_rxda_i   = 1'b0;
    bus.mac_rxsop_i  = 1'b0;
    bus.mac_rxeop_i  = 1'b0;
    bus.mac_rxdv_i   = 1'b0;
    bus.buf_rd_ptr_i = '0;
    bus.desc_ready_i = 1'b0;
    last_desc        = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 100-byte frame
    send_frame(25, 2'b00, 1'b1, -1, -1, 0);
    check("t1_addr", 64'(last_desc.addr), 64'd0);
    check("t1_len", 64'(last_desc.len), 64'd100);
    check("t1_err", 64'(last_desc.err), 64'd0);
    check("t1_wptr", 64'(bus.wr_ptr_o), 64'd25);

    // 61-byte frame then a back-to-back frame with a held descriptor
    do_reset();
    send_frame(16, 2'b01, 1'b1, -1, -1, 0);
    check("t2_len", 64'(last_desc.len), 64'd61);
    send_frame(16, 2'b10, 1'b1, -1, -1, 3);
    check("t2_addr2", 64'(last_desc.addr), 64'd16);
    check("t2_len2", 64'(last_desc.len), 64'd62);

    // single-word frame, missing SOP, stray SOP mid-frame
    send_frame(1, 2'b11, 1'b1, -1, -1, 0);
    check("sw_addr", 64'(last_desc.addr), 64'd32);
    check("sw_len", 64'(last_desc.len), 64'd3);
    send_frame(3, 2'b00, 1'b0, -1, -1, 0);
    check("nosop_err", 64'(last_desc.err), 64'd1);
    send_frame(8, 2'b00, 1'b1, 4, -1, 1);
    check("badsop_err", 64'(last_desc.err), 64'd1);
    check("badsop_len", 64'(last_desc.len), 64'd0);
    check("badsop_wptr", 64'(bus.wr_ptr_o), 64'd33);
    send_frame(2, 2'b00, 1'b1, -1, -1, 0);
    check("after_drop_addr", 64'(last_desc.addr), 64'd33);

    // Fill to 4000 words, then admission stall
    do_reset();
    send_frame(MAXW, 2'b00, 1'b1, -1, -1, 0);
    check("max_len", 64'(last_desc.len), 64'd1520);
    check("max_err", 64'(last_desc.err), 64'd0);
    for (int f = 1; f < 10; f++) send_frame(MAXW, 2'(f), 1'b1, -1, -1, 0);
    send_frame(200, 2'b00, 1'b1, -1, -1, 0);
    check("fill_wptr", 64'(bus.wr_ptr_o), 64'd4000);
    bus.buf_rd_ptr_i = '0;
    bus.mac_rxda_i   = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      check("stall_rqrd", 64'(bus.mac_rxrqrd_o), 64'd0);
    end
    bus.buf_rd_ptr_i = 13'd300;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("admit_rqrd", 64'(bus.mac_rxrqrd_o), 64'd1);
    send_frame(90, 2'b00, 1'b1, -1, -1, 0);
    check("pre_wrap_wptr", 64'(bus.wr_ptr_o), 64'd4090);

    // Wrap
    send_frame(10, 2'b00, 1'b1, -1, -1, 0);
    check("wrap_addr", 64'(last_desc.addr), 64'd4090);
    check("wrap_wptr", 64'(bus.wr_ptr_o), 64'd4100);
    check("wrap_bit", 64'(bus.wr_ptr_o[AW]), 64'd1);

    // Oversize
    send_frame(400, 2'b00, 1'b1, -1, -1, 0);
    check("big_err", 64'(last_desc.err), 64'd1);
    check("big_len", 64'(last_desc.len), 64'd0);
    check("big_wptr", 64'(bus.wr_ptr_o), 64'd4100);

    // Reset in the middle of a frame
    send_frame(20, 2'b00, 1'b1, -1, 10, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_frame(5, 2'b00, 1'b1, -1, -1, 0);
    check("post_rst_addr", 64'(last_desc.addr), 64'd0);
    check("post_rst_wptr", 64'(bus.wr_ptr_o), 64'd5);

    check("desc_q_empty", 64'(exp_desc_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog
  initial begin
    #1500000;
    fail_now("watchdog");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
